// File: rtl/sram_req_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// sram_req_arbiter_pkg
//   Shared definitions for the SRAM-like port arbiter:
//     - order-FIFO tag values (which master issued an accepted request)
//     - SRAM-like transfer size encodings
//     - master-select enum used by the grant logic
// ---------------------------------------------------------------------------
package sram_req_arbiter_pkg;

  // Tag stored per accepted request in the order FIFO.
  localparam logic ARB_TAG_INST = 1'b0;
  localparam logic ARB_TAG_DATA = 1'b1;

  // SRAM-like size field encodings.
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  // Master select; encoding matches the tag values so a grant can be pushed
  // into the order FIFO directly.
  typedef enum logic {
    MST_INST = 1'b0,
    MST_DATA = 1'b1
  } arb_mst_e;

endpackage : sram_req_arbiter_pkg

// File: rtl/sram_req_arbiter_arb_order_fifo.sv
// ---------------------------------------------------------------------------
// arb_order_fifo
//   Synchronous 1-bit-wide FIFO holding the issue order of accepted requests.
//   A push while full and a pop while empty are ignored. A push and a pop in
//   the same cycle leave the count unchanged; on an empty FIFO the pop is
//   ignored, so the pushed entry is never matched by a same-cycle response.
//
// Parameters:
//   DEPTH       number of entries (>= 2)
// Ports:
//   clk         clock
//   reset       synchronous active-high reset (empties the FIFO)
//   i_push      write i_push_tag at the tail
//   i_push_tag  tag to store
//   i_pop       drop the head entry
//   o_head      tag at the head (valid when ~o_empty)
//   o_full      count == DEPTH
//   o_empty     count == 0
// ---------------------------------------------------------------------------
module arb_order_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_push,
  input  logic i_push_tag,
  input  logic i_pop,
  output logic o_head,
  output logic o_full,
  output logic o_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] r_tags;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  // Pointers wrap modulo DEPTH, which also covers non-power-of-two depths.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_head  = r_tags[r_rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the tag storage is deliberately not reset; an entry is only read
  // after it has been written, because the count gates every pop.
  always_ff @(posedge clk) begin
    if (w_push) r_tags[r_wr_ptr] <= i_push_tag;
  end

endmodule : arb_order_fifo

// File: rtl/sram_req_arbiter.sv
// ---------------------------------------------------------------------------
// sram_req_arbiter
//   Shares one SRAM-like memory port between the instruction-fetch master
//   (inst_sram_*) and the data master (data_sram_*). One request is selected
//   per cycle; a request that is presented but not accepted locks the grant
//   so the memory side sees a stable request until mem_addr_ok. The issue
//   order of accepted requests is kept in arb_order_fifo and each in-order
//   mem_data_ok/mem_rdata response is routed back to the master that issued
//   the matching request.
//
// Build option:
//   SRAM_ARB_RR_EN  when defined, a last_grant flop (reset = data) makes the
//                   arbitration round-robin when both masters request and no
//                   lock is held. Undefined: fixed data priority.
//
// Parameters:
//   DEPTH  maximum accepted requests still waiting for data_ok (>= 2)
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   inst_sram_*                instruction master (read-only, word size)
//   data_sram_*                data master (read/write, byte/half/word)
//   mem_req/wr/size/wstrb/addr/wdata   shared port request (to bridge)
//   mem_addr_ok/data_ok/rdata          shared port handshake (from bridge)
// ---------------------------------------------------------------------------
module sram_req_arbiter
  import sram_req_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  // instruction master
  input  logic        inst_sram_req,
  input  logic [31:0] inst_sram_addr,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  // data master
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  // shared memory port
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  arb_mst_e r_lock_mst;
  logic     r_lock;
  arb_mst_e w_gnt;
  logic     w_gnt_req;
  logic     w_accept;
  logic     w_full;
  logic     w_empty;
  logic     w_head;
  logic     w_push_tag;

`ifdef SRAM_ARB_RR_EN
  arb_mst_e r_last_gnt;
`endif

  // -------------------------------------------------------------------------
  // Grant selection
  // -------------------------------------------------------------------------
  // NOTE: every signal driven from always_comb gets a default first so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    w_gnt = MST_DATA;
    if (r_lock) begin
      w_gnt = r_lock_mst;
    end else if (inst_sram_req && data_sram_req) begin
`ifdef SRAM_ARB_RR_EN
      w_gnt = (r_last_gnt == MST_DATA) ? MST_INST : MST_DATA;
`else
      w_gnt = MST_DATA;
`endif
    end else if (inst_sram_req) begin
      w_gnt = MST_INST;
    end
  end

  assign w_gnt_req = (w_gnt == MST_DATA) ? data_sram_req : inst_sram_req;

  // -------------------------------------------------------------------------
  // Issue path
  // -------------------------------------------------------------------------
  assign mem_req  = w_gnt_req & ~w_full;
  assign w_accept = mem_req & mem_addr_ok;

  assign inst_sram_addr_ok = w_accept & (w_gnt == MST_INST);
  assign data_sram_addr_ok = w_accept & (w_gnt == MST_DATA);

  // Request fields are zero when the granted master is idle, so the port is
  // quiet whenever nobody requests.
  always_comb begin
    mem_wr    = 1'b0;
    mem_size  = SIZE_B;
    mem_wstrb = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_gnt_req) begin
      if (w_gnt == MST_DATA) begin
        mem_wr    = data_sram_wr;
        mem_size  = data_sram_size;
        mem_wstrb = data_sram_wstrb;
        mem_addr  = data_sram_addr;
        mem_wdata = data_sram_wdata;
      end else begin
        mem_size  = SIZE_W;
        mem_addr  = inst_sram_addr;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Grant lock: hold the presented-but-unaccepted request stable. A locked
  // master that drops its request releases the lock; while the FIFO is full
  // the held request is simply kept waiting.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lock     <= 1'b0;
      r_lock_mst <= MST_DATA;
    end else if (mem_req && !mem_addr_ok) begin
      r_lock     <= 1'b1;
      r_lock_mst <= w_gnt;
    end else if (w_accept) begin
      r_lock     <= 1'b0;
    end else if (r_lock && !w_gnt_req) begin
      r_lock     <= 1'b0;
    end
  end

`ifdef SRAM_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_gnt <= MST_DATA;
    end else if (w_accept) begin
      r_last_gnt <= w_gnt;
    end
  end
`endif

  // -------------------------------------------------------------------------
  // Order FIFO and response routing
  // -------------------------------------------------------------------------
  assign w_push_tag = (w_gnt == MST_DATA) ? ARB_TAG_DATA : ARB_TAG_INST;

  arb_order_fifo #(
    .DEPTH (DEPTH)
  ) u_order_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_push     (w_accept),
    .i_push_tag (w_push_tag),
    .i_pop      (mem_data_ok),
    .o_head     (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  // A response arriving with nothing outstanding is dropped.
  assign inst_sram_data_ok = mem_data_ok & ~w_empty & (w_head == ARB_TAG_INST);
  assign data_sram_data_ok = mem_data_ok & ~w_empty & (w_head == ARB_TAG_DATA);
  assign inst_sram_rdata   = mem_rdata;
  assign data_sram_rdata   = mem_rdata;

endmodule : sram_req_arbiter

// File: tb/tb_sram_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_req_arbiter
//   Self-checking bench for sram_req_arbiter (DEPTH = 4). Directed scenarios
//   use hand-derived expected values; the randomized scenario compares every
//   output against a transaction-level model (a queue of issuing masters, a
//   held-master flag and, with SRAM_ARB_RR_EN, the last granted master).
// ---------------------------------------------------------------------------
module tb_sram_req_arbiter;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_req_arbiter #(.DEPTH(DEPTH)) dut (
    .clk               (clk),
    .reset             (reset),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata),
    .data_sram_req     (data_sram_req),
    .data_sram_wr      (data_sram_wr),
    .data_sram_size    (data_sram_size),
    .data_sram_wstrb   (data_sram_wstrb),
    .data_sram_addr    (data_sram_addr),
    .data_sram_wdata   (data_sram_wdata),
    .data_sram_addr_ok (data_sram_addr_ok),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .mem_req           (mem_req),
    .mem_wr            (mem_wr),
    .mem_size          (mem_size),
    .mem_wstrb         (mem_wstrb),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .mem_addr_ok       (mem_addr_ok),
    .mem_data_ok       (mem_data_ok),
    .mem_rdata         (mem_rdata)
  );

  // -------------------------------------------------------------------------
  // Reference model (1 = data master, 0 = inst master)
  // -------------------------------------------------------------------------
  bit q_owner[$];     // masters of accepted, unanswered requests, oldest first
  bit held = 0;       // a presented request is waiting for acceptance
  bit held_by = 0;
  bit last_won = 1;   // last accepted master, used for round-robin

  bit          e_gnt, e_gnt_req, e_mem_req;
  bit          e_inst_aok, e_data_aok, e_inst_dok, e_data_dok;
  logic        e_wr;
  logic [1:0]  e_size;
  logic [3:0]  e_wstrb;
  logic [31:0] e_addr, e_wdata;

  function automatic void model_eval();
    if (held) e_gnt = held_by;
    else if (inst_sram_req && data_sram_req) begin
`ifdef SRAM_ARB_RR_EN
      e_gnt = !last_won;
`else
      e_gnt = 1'b1;
`endif
    end else e_gnt = !(inst_sram_req && !data_sram_req);
    e_gnt_req = e_gnt ? data_sram_req : inst_sram_req;
    e_mem_req = e_gnt_req && (q_owner.size() < DEPTH);
    {e_wr, e_size, e_wstrb, e_addr, e_wdata} = '0;
    if (e_gnt_req && e_gnt)
      {e_wr, e_size, e_wstrb, e_addr, e_wdata} =
        {data_sram_wr, data_sram_size, data_sram_wstrb, data_sram_addr, data_sram_wdata};
    else if (e_gnt_req)
      {e_size, e_addr} = {2'd2, inst_sram_addr};
    e_inst_aok = e_mem_req && mem_addr_ok && !e_gnt;
    e_data_aok = e_mem_req && mem_addr_ok && e_gnt;
    e_inst_dok = mem_data_ok && (q_owner.size() > 0) && (q_owner[0] == 1'b0);
    e_data_dok = mem_data_ok && (q_owner.size() > 0) && (q_owner[0] == 1'b1);
  endfunction

  // Advance one clock: the model consumes the inputs present at the edge,
  // then new inputs may be driven 1 time unit later.
  task automatic tick();
    bit popped, pushed;
    model_eval();
    @(posedge clk);
    if (reset) begin
      q_owner.delete();
      held     = 0;
      last_won = 1;
    end else begin
      popped = mem_data_ok && (q_owner.size() > 0);
      pushed = e_mem_req && mem_addr_ok;
      if (popped) void'(q_owner.pop_front());
      if (pushed) begin
        q_owner.push_back(e_gnt);
        last_won = e_gnt;
      end
      if (e_mem_req && !mem_addr_ok) begin
        held    = 1;
        held_by = e_gnt;
      end else if (pushed || (held && !e_gnt_req)) begin
        held = 0;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    inst_sram_req   = 0; inst_sram_addr  = '0;
    data_sram_req   = 0; data_sram_wr    = 0; data_sram_size = '0;
    data_sram_wstrb = '0; data_sram_addr = '0; data_sram_wdata = '0;
    mem_addr_ok     = 0; mem_data_ok     = 0; mem_rdata      = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  // -------------------------------------------------------------------------
  // Scenarios
  // -------------------------------------------------------------------------
  task automatic test_reset();
    logic [143:0] act;
    do_reset();
    @(negedge clk);
    act = {inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
           data_sram_addr_ok, data_sram_data_ok, data_sram_rdata,
           mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata};
    checks++;
    if (act !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", act);
    end
    tick();
  endtask

  task automatic test_priority();
    inst_sram_req = 1; inst_sram_addr = 32'h0000_1000;
    data_sram_req = 1; data_sram_wr = 1; data_sram_size = 2'd2;
    data_sram_wstrb = 4'hf; data_sram_addr = 32'h0000_2000;
    data_sram_wdata = 32'hdead_beef; mem_addr_ok = 1;
    @(negedge clk);
    checks++;
    if ({mem_req, inst_sram_addr_ok, data_sram_addr_ok} !== 3'b101) begin
      errors++;
      $display("FAIL prio_handshake: got req/iaok/daok %b want 101",
               {mem_req, inst_sram_addr_ok, data_sram_addr_ok});
    end
    checks++;
    if ({mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata} !==
        {1'b1, 2'd2, 4'hf, 32'h0000_2000, 32'hdead_beef}) begin
      errors++;
      $display("FAIL prio_fields: got wr=%b sz=%0d st=%h a=%h d=%h",
               mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata);
    end
    tick();
    idle_inputs();
    mem_data_ok = 1; mem_rdata = 32'h0000_0055;
    @(negedge clk);
    checks++;
    if ({inst_sram_data_ok, data_sram_data_ok, data_sram_rdata} !== {2'b01, 32'h55}) begin
      errors++;
      $display("FAIL prio_resp: got idok/ddok %b rdata %h want 01 / 55",
               {inst_sram_data_ok, data_sram_data_ok}, data_sram_rdata);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_lock();
    inst_sram_req = 1; inst_sram_addr = 32'h0000_0100;
    for (int c = 0; c < 4; c++) begin
      if (c >= 1) begin data_sram_req = 1; data_sram_addr = 32'h0000_0200; end
      mem_addr_ok = (c == 3);
      @(negedge clk);
      checks++;
      if ({mem_req, mem_addr, inst_sram_addr_ok, data_sram_addr_ok} !==
          {1'b1, 32'h0000_0100, (c == 3), 1'b0}) begin
        errors++;
        $display("FAIL lock_hold c%0d: got req=%b addr=%h iaok=%b daok=%b", c,
                 mem_req, mem_addr, inst_sram_addr_ok, data_sram_addr_ok);
      end
      tick();
    end
    inst_sram_addr = 32'h0000_0104;
    @(negedge clk);
    checks++;
    if ({mem_addr, inst_sram_addr_ok, data_sram_addr_ok} !== {32'h0000_0200, 2'b01}) begin
      errors++;
      $display("FAIL lock_release: got addr=%h iaok=%b daok=%b want 200 0 1",
               mem_addr, inst_sram_addr_ok, data_sram_addr_ok);
    end
    tick();
    idle_inputs();
    mem_data_ok = 1;
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      checks++;
      if ({inst_sram_data_ok, data_sram_data_ok} !== ((r == 0) ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL lock_resp%0d: got idok/ddok %b", r, {inst_sram_data_ok, data_sram_data_ok});
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_order();
    mem_addr_ok = 1;
    for (int k = 0; k < 3; k++) begin
      inst_sram_req = (k != 1); inst_sram_addr = 32'h0000_0300;
      data_sram_req = (k == 1); data_sram_addr = 32'h0000_0400;
      tick();
    end
    idle_inputs();
    mem_data_ok = 1;
    for (int k = 0; k < 3; k++) begin
      logic [31:0] rd;
      rd = 32'h11 * (k + 1);
      mem_rdata = rd;
      @(negedge clk);
      checks++;
      if ({inst_sram_data_ok, data_sram_data_ok, inst_sram_rdata, data_sram_rdata} !==
          {(k != 1), (k == 1), rd, rd}) begin
        errors++;
        $display("FAIL order_resp%0d: got idok=%b ddok=%b irdata=%h drdata=%h want rdata %h",
                 k, inst_sram_data_ok, data_sram_data_ok, inst_sram_rdata, data_sram_rdata, rd);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_full();
    inst_sram_req = 1; inst_sram_addr = 32'h0000_0500; mem_addr_ok = 1;
    for (int k = 0; k < DEPTH + 1; k++) begin
      @(negedge clk);
      checks++;
      if ({mem_req, inst_sram_addr_ok} !== ((k < DEPTH) ? 2'b11 : 2'b00)) begin
        errors++;
        $display("FAIL full_fill%0d: got req/iaok %b", k, {mem_req, inst_sram_addr_ok});
      end
      tick();
    end
    // Response while full: pop only, the pending request stays blocked.
    mem_data_ok = 1;
    @(negedge clk);
    checks++;
    if ({mem_req, inst_sram_addr_ok, inst_sram_data_ok} !== 3'b001) begin
      errors++;
      $display("FAIL full_pop: got req/iaok/idok %b want 001",
               {mem_req, inst_sram_addr_ok, inst_sram_data_ok});
    end
    tick();
    // At DEPTH-1: push and pop together keep the count at DEPTH-1.
    @(negedge clk);
    checks++;
    if ({mem_req, inst_sram_addr_ok, inst_sram_data_ok} !== 3'b111) begin
      errors++;
      $display("FAIL full_pushpop: got req/iaok/idok %b want 111",
               {mem_req, inst_sram_addr_ok, inst_sram_data_ok});
    end
    tick();
    mem_data_ok = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (mem_req !== (k == 0)) begin
        errors++;
        $display("FAIL full_refill%0d: got mem_req %b", k, mem_req);
      end
      tick();
    end
    idle_inputs();
    mem_data_ok = 1;
    for (int k = 0; k < DEPTH + 1; k++) begin
      @(negedge clk);
      checks++;
      if (inst_sram_data_ok !== (k < DEPTH)) begin
        errors++;
        $display("FAIL full_drain%0d: got idok %b", k, inst_sram_data_ok);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_empty_drop();
    mem_data_ok = 1;
    @(negedge clk);
    checks++;
    if ({inst_sram_data_ok, data_sram_data_ok} !== 2'b00) begin
      errors++;
      $display("FAIL empty_drop: got idok/ddok %b want 00", {inst_sram_data_ok, data_sram_data_ok});
    end
    tick();
    // Accept on empty with a same-cycle response: the response cannot match.
    data_sram_req = 1; data_sram_addr = 32'h0000_0600; mem_addr_ok = 1;
    @(negedge clk);
    checks++;
    if ({data_sram_addr_ok, data_sram_data_ok} !== 2'b10) begin
      errors++;
      $display("FAIL empty_same_cycle: got daok/ddok %b want 10", {data_sram_addr_ok, data_sram_data_ok});
    end
    tick();
    data_sram_req = 0; mem_addr_ok = 0;
    @(negedge clk);
    checks++;
    if (data_sram_data_ok !== 1'b1) begin
      errors++;
      $display("FAIL empty_then_resp: got ddok %b want 1", data_sram_data_ok);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_outstanding();
    mem_addr_ok = 1;
    inst_sram_req = 1; tick();
    inst_sram_req = 0; data_sram_req = 1; tick();
    data_sram_req = 0; inst_sram_req = 1; mem_addr_ok = 0; tick();  // locks inst
    reset = 1; idle_inputs(); tick();
    reset = 0;
    @(negedge clk);
    checks++;
    if ({mem_req, inst_sram_addr_ok, data_sram_addr_ok, mem_addr} !== '0) begin
      errors++;
      $display("FAIL rst_out_idle: got req=%b addr=%h", mem_req, mem_addr);
    end
    tick();
    mem_data_ok = 1;
    @(negedge clk);
    checks++;
    if ({inst_sram_data_ok, data_sram_data_ok} !== 2'b00) begin
      errors++;
      $display("FAIL rst_fifo_cleared: got idok/ddok %b want 00", {inst_sram_data_ok, data_sram_data_ok});
    end
    tick();
    mem_data_ok = 0; data_sram_req = 1; data_sram_addr = 32'h0000_0700;
    @(negedge clk);
    checks++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h0000_0700}) begin
      errors++;
      $display("FAIL rst_lock_cleared: got req=%b addr=%h want 1 700", mem_req, mem_addr);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_both_held();
    bit want_data;
    do_reset();
    inst_sram_req = 1; data_sram_req = 1; mem_addr_ok = 1;
    for (int k = 0; k < DEPTH; k++) begin
`ifdef SRAM_ARB_RR_EN
      want_data = (k % 2 == 1);
`else
      want_data = 1'b1;
`endif
      @(negedge clk);
      checks++;
      if ({inst_sram_addr_ok, data_sram_addr_ok} !== {!want_data, want_data}) begin
        errors++;
        $display("FAIL both_held%0d: got iaok/daok %b", k, {inst_sram_addr_ok, data_sram_addr_ok});
      end
      tick();
    end
    idle_inputs();
    mem_data_ok = 1;
    for (int k = 0; k < DEPTH; k++) tick();
    idle_inputs();
  endtask

  task automatic test_random();
    logic [75:0] act, exp;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      reset           = ($urandom_range(0, 99) == 0);
      inst_sram_req   = ($urandom_range(0, 99) < 60);
      inst_sram_addr  = $urandom;
      data_sram_req   = ($urandom_range(0, 99) < 50);
      data_sram_wr    = $urandom_range(0, 1);
      data_sram_size  = 2'($urandom_range(0, 2));
      data_sram_wstrb = 4'($urandom);
      data_sram_addr  = $urandom;
      data_sram_wdata = $urandom;
      mem_addr_ok     = ($urandom_range(0, 99) < 50);
      mem_data_ok     = ($urandom_range(0, 99) < 40);
      mem_rdata       = $urandom;
      @(negedge clk);
      model_eval();
      act = {mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
             inst_sram_addr_ok, data_sram_addr_ok, inst_sram_data_ok, data_sram_data_ok};
      exp = {e_mem_req, e_wr, e_size, e_wstrb, e_addr, e_wdata,
             e_inst_aok, e_data_aok, e_inst_dok, e_data_dok};
      checks++;
      if (act !== exp || inst_sram_rdata !== mem_rdata || data_sram_rdata !== mem_rdata) begin
        errors++;
        $display("FAIL random c%0d: got %h want %h (rdata i=%h d=%h want %h)",
                 c, act, exp, inst_sram_rdata, data_sram_rdata, mem_rdata);
      end
      tick();
    end
    reset = 0;
    idle_inputs();
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    test_reset();
    test_priority();
    test_lock();
    test_order();
    test_full();
    test_empty_drop();
    test_reset_outstanding();
    test_both_held();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_sram_req_arbiter
